// File: rtl/stream_pkg.sv
// Shared helpers for the stream FIFO: level width and
// modulo pointer advance for non-power-of-two RAM depths.
package stream_pkg;

    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int unsigned wrap_inc(
        input int unsigned p,
        input int unsigned n
    );
        return (p + 32'd1 >= n) ? 32'd0 : p + 32'd1;
    endfunction

endpackage

// File: rtl/stream_if.sv
// Valid/ready stream bundle with producer and consumer views.
interface stream_if #(
    parameter int DATA_WIDTH = 64
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (
        output tdata,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/stream_fifo_ram.sv
// Simple dual-port storage: one synchronous write,
// one asynchronous read, no reset.
module stream_fifo_ram #(
    parameter int DATA_WIDTH = 64,
    parameter int WORDS      = 15,
    parameter int AW         = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/stream_fifo.sv
// First-word-fall-through FIFO: RAM of DEPTH-1 words plus a
// registered head word, with level and almost-full reporting.
module stream_fifo
    import stream_pkg::*;
#(
    parameter int DATA_WIDTH   = 64,
    parameter int DEPTH        = 16,
    parameter int AFULL_THRESH = DEPTH - 2
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    stream_if.slave                   s,
    stream_if.master                  m,
    output logic [level_w(DEPTH)-1:0] level,
    output logic                      almost_full
);
    localparam int unsigned RAM_D = DEPTH - 1;
    localparam int          PW    = $clog2(RAM_D);
    localparam int          LW    = level_w(DEPTH);

    typedef logic [PW-1:0]         ptr_t;
    typedef logic [LW-1:0]         lvl_t;
    typedef logic [DATA_WIDTH-1:0] data_t;

    localparam lvl_t FULL_LVL = lvl_t'(DEPTH);
    localparam lvl_t AF_LVL   = lvl_t'(AFULL_THRESH);

    ptr_t  wr_ptr, wr_ptr_n;
    ptr_t  rd_ptr, rd_ptr_n;
    lvl_t  level_n;
    data_t out_q, out_n;
    data_t ram_rdata;
    logic  vld_q, rdy_q;
    logic  push, pop, ram_empty;
    logic  bypass, ram_we, load;

    assign m.tdata  = out_q;
    assign m.tvalid = vld_q;
    assign s.tready = rdy_q;

    stream_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .WORDS      (RAM_D),
        .AW         (PW)
    ) u_ram (
        .clk   (ACLK),
        .we    (ram_we),
        .waddr (wr_ptr),
        .wdata (s.tdata),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    always_comb begin
        push      = s.tvalid && rdy_q;
        pop       = vld_q && m.tready;
        // head word sits in out_q, so RAM holds level-1 words
        ram_empty = (level <= lvl_t'(1));
        bypass    = push && (!vld_q || (pop && ram_empty));
        ram_we    = push && !bypass;
        load      = pop && !ram_empty;
        wr_ptr_n  = wr_ptr;
        rd_ptr_n  = rd_ptr;
        out_n     = out_q;
        level_n   = level;
        if (ram_we)
            wr_ptr_n = ptr_t'(wrap_inc(32'(wr_ptr), RAM_D));
        if (load)
            rd_ptr_n = ptr_t'(wrap_inc(32'(rd_ptr), RAM_D));
        if (bypass)
            out_n = s.tdata;
        else if (load)
            out_n = ram_rdata;
        case ({push, pop})
            2'b10:   level_n = level + lvl_t'(1);
            2'b01:   level_n = level - lvl_t'(1);
            default: level_n = level;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            out_q       <= '0;
            level       <= '0;
            vld_q       <= 1'b0;
            rdy_q       <= 1'b0;
            almost_full <= 1'b0;
        end else begin
            wr_ptr      <= wr_ptr_n;
            rd_ptr      <= rd_ptr_n;
            out_q       <= out_n;
            level       <= level_n;
            vld_q       <= (level_n != '0);
            rdy_q       <= (level_n < FULL_LVL);
            almost_full <= (level_n >= AF_LVL);
        end
    end
endmodule

// File: tb/tb_stream_fifo.sv
// Directed and random checks of stream_fifo with a queue model.
module tb_stream_fifo;
    logic       clk;
    logic       rst;
    logic [4:0] level;
    logic       almost_full;

    stream_if #(.DATA_WIDTH(64)) s_if ();
    stream_if #(.DATA_WIDTH(64)) m_if ();

    stream_fifo #(
        .DATA_WIDTH   (64),
        .DEPTH        (16),
        .AFULL_THRESH (14)
    ) dut (
        .ACLK        (clk),
        .ARESET      (rst),
        .s           (s_if),
        .m           (m_if),
        .level       (level),
        .almost_full (almost_full)
    );

    int checks   = 0;
    int failures = 0;
    logic [63:0] q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(
        input string       tag,
        input logic [63:0] got,
        input logic [63:0] exp
    );
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_rdy"}, 64'(s_if.tready), 64'd0);
        check({tag, "_vld"}, 64'(m_if.tvalid), 64'd0);
        check({tag, "_lvl"}, 64'(level), 64'd0);
        check({tag, "_af"}, 64'(almost_full), 64'd0);
        check({tag, "_dat"}, m_if.tdata, 64'd0);
    endtask

    task automatic cyc();
        logic push, pop, hold;
        logic [63:0] hd;
        push = s_if.tvalid && s_if.tready;
        pop  = m_if.tvalid && m_if.tready;
        hold = m_if.tvalid && !m_if.tready;
        hd   = m_if.tdata;
        if (pop) begin
            check("q_nonempty", 64'(q.size() != 0), 64'd1);
            if (q.size() != 0)
                check("order", m_if.tdata, q.pop_front());
        end
        if (push) q.push_back(s_if.tdata);
        @(posedge clk);
        #1;
        check("level", 64'(level), 64'(q.size()));
        if (hold) begin
            check("hold_v", 64'(m_if.tvalid), 64'd1);
            check("hold_d", m_if.tdata, hd);
        end
    endtask

    initial begin
        int pops;
        int cycles;
        bit did_rst;
        rst         = 1'b1;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        m_if.tready = 1'b0;

        repeat (3) begin
            @(posedge clk);
            #1;
            chk_zero("rst");
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rel_rdy", 64'(s_if.tready), 64'd1);
        check("rel_lvl", 64'(level), 64'd0);

        s_if.tvalid = 1'b1;
        s_if.tdata  = 64'hA5;
        cyc();
        s_if.tvalid = 1'b0;
        check("one_vld", 64'(m_if.tvalid), 64'd1);
        check("one_dat", m_if.tdata, 64'hA5);
        check("one_lvl", 64'(level), 64'd1);
        repeat (2) cyc();
        check("one_hold", m_if.tdata, 64'hA5);
        m_if.tready = 1'b1;
        cyc();
        m_if.tready = 1'b0;
        check("one_empty", 64'(m_if.tvalid), 64'd0);
        check("one_keep", m_if.tdata, 64'hA5);

        for (int i = 0; i < 16; i++) begin
            check("fill_rdy", 64'(s_if.tready), 64'd1);
            s_if.tvalid = 1'b1;
            s_if.tdata  = 64'(i);
            cyc();
            check("fill_af", 64'(almost_full), 64'(i + 1 >= 14));
        end
        check("full_rdy", 64'(s_if.tready), 64'd0);
        check("full_lvl", 64'(level), 64'd16);
        s_if.tdata = 64'd99;
        cyc();
        s_if.tvalid = 1'b0;
        check("over_lvl", 64'(level), 64'd16);

        m_if.tready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("drain_dat", m_if.tdata, 64'(i));
            cyc();
            if (i == 0)
                check("drain_rdy", 64'(s_if.tready), 64'd1);
        end
        check("drain_vld", 64'(m_if.tvalid), 64'd0);
        check("drain_lvl", 64'(level), 64'd0);
        m_if.tready = 1'b0;

        for (int i = 0; i < 5; i++) begin
            s_if.tvalid = 1'b1;
            s_if.tdata  = 64'(100 + i);
            cyc();
        end
        m_if.tready = 1'b1;
        for (int k = 0; k < 200; k++) begin
            s_if.tdata = 64'(105 + k);
            cyc();
            check("stream_lvl", 64'(level), 64'd5);
        end
        s_if.tvalid = 1'b0;
        repeat (5) cyc();
        check("stream_end", 64'(level), 64'd0);
        m_if.tready = 1'b0;

        pops    = 0;
        cycles  = 0;
        did_rst = 1'b0;
        while (pops < 10000 && cycles < 60000) begin
            s_if.tvalid = 1'($urandom_range(0, 1));
            s_if.tdata  = {$urandom(), $urandom()};
            m_if.tready = 1'($urandom_range(0, 1));
            if (m_if.tvalid && m_if.tready) pops++;
            cyc();
            cycles++;
            if (!did_rst && pops >= 3000) begin
                did_rst = 1'b1;
                rst = 1'b1;
                #1;
                chk_zero("arst");
                s_if.tvalid = 1'b0;
                m_if.tready = 1'b0;
                q.delete();
                repeat (2) @(posedge clk);
                #1;
                rst = 1'b0;
                @(posedge clk);
                #1;
                check("arst_rdy", 64'(s_if.tready), 64'd1);
                check("arst_vld", 64'(m_if.tvalid), 64'd0);
                check("arst_lvl", 64'(level), 64'd0);
            end
        end
        check("rand_done", 64'(pops >= 10000), 64'd1);

        s_if.tvalid = 1'b0;
        m_if.tready = 1'b1;
        repeat (20) cyc();
        check("final_vld", 64'(m_if.tvalid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
